// File: rtl/div_pow2_round_pipe_pkg.sv
// Shared definitions for the divide-by-2^SHIFT rounding pipeline.
// Contents: rounding-mode codes and a signed saturation helper.
package div_round_pkg;

  typedef logic [1:0] round_mode_t;

  localparam round_mode_t MODE_TRUNC     = 2'd0;
  localparam round_mode_t MODE_HALF_AWAY = 2'd1;
  localparam round_mode_t MODE_HALF_EVEN = 2'd2;
  localparam round_mode_t MODE_FLOOR     = 2'd3;

  // Clamp a signed value into the range of a signed 'width'-bit number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int unsigned width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/div_pow2_round_pipe_if.sv
// Streaming bus for the divide/round pipeline.
// Upstream side : in_valid, in_ready, in_data (lanes packed, lane 0 in LSBs), in_mode.
// Downstream side: out_valid, out_ready, out_data (lanes packed, lane 0 in LSBs), out_sat.
interface div_pow2_round_pipe_if #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned IN_WIDTH  = 12,
  parameter int unsigned OUT_WIDTH = 9
);
  import div_round_pkg::*;

  logic                            in_valid;
  logic                            in_ready;
  logic [CHANNELS*IN_WIDTH-1:0]    in_data;
  round_mode_t                     in_mode;
  logic                            out_valid;
  logic                            out_ready;
  logic [CHANNELS*OUT_WIDTH-1:0]   out_data;
  logic [CHANNELS-1:0]             out_sat;

  // Producer/consumer view (drives inputs, receives results).
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // Pipeline view.
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/div_pow2_round_pipe_lane.sv
// One lane of the divide-by-2^SHIFT pipeline: magnitude, round, re-sign, saturate.
// Ports: clk, rst_n, adv (shared pipeline advance), mode_s1 (mode of the beat in stage 1),
//        in_sample (signed input), out_sample (signed result), out_sat (saturation flag).
module div_round_lane
  import div_round_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 12,
  parameter int unsigned OUT_WIDTH = 9,
  parameter int unsigned SHIFT     = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        adv,
  input  round_mode_t                 mode_s1,
  input  logic signed [IN_WIDTH-1:0]  in_sample,
  output logic signed [OUT_WIDTH-1:0] out_sample,
  output logic                        out_sat
);

  // One extra bit so |most-negative| is representable.
  localparam int unsigned MW = IN_WIDTH + 1;

  logic                        sign1_q, sign1_d;
  logic [MW-1:0]               mag1_q, mag1_d;
  logic                        sign2_q, sign2_d;
  logic [MW-1:0]               sum2_q, sum2_d;
  logic signed [OUT_WIDTH-1:0] res3_q, res3_d;
  logic                        sat3_q, sat3_d;

  logic signed [MW-1:0] ext_c;
  logic [MW-1:0]        mag_c;
  logic [MW-1:0]        quot_c;
  logic                 guard_c;
  logic                 sticky_c;
  logic                 inc_c;
  logic signed [MW-1:0] res_c;
  logic signed [31:0]   res_ext_c;
  logic signed [31:0]   clamp_c;

  // Guard/sticky extraction; with no shift there are no discarded bits.
  if (SHIFT == 0) begin : g_noshift
    assign guard_c  = 1'b0;
    assign sticky_c = 1'b0;
  end else begin : g_shift
    localparam logic [MW-1:0] STICKY_MASK = MW'((64'd1 << (SHIFT - 1)) - 64'd1);
    assign guard_c  = mag1_q[SHIFT-1];
    assign sticky_c = |(mag1_q & STICKY_MASK);
  end

  // Datapath next-state; every stage holds while the pipeline is stalled.
  always_comb begin
    sign1_d = sign1_q;
    mag1_d  = mag1_q;
    sign2_d = sign2_q;
    sum2_d  = sum2_q;
    res3_d  = res3_q;
    sat3_d  = sat3_q;

    ext_c  = MW'(in_sample);
    mag_c  = in_sample[IN_WIDTH-1] ? MW'(-ext_c) : MW'(ext_c);
    quot_c = mag1_q >> SHIFT;

    unique case (mode_s1)
      MODE_TRUNC:     inc_c = 1'b0;
      MODE_HALF_AWAY: inc_c = guard_c;
      MODE_HALF_EVEN: inc_c = guard_c & (sticky_c | quot_c[0]);
      MODE_FLOOR:     inc_c = sign1_q & (guard_c | sticky_c);
      default:        inc_c = 1'b0;
    endcase

    // Zero magnitude negates to zero, so no -0 and no spurious saturation.
    res_c     = sign2_q ? -$signed(sum2_q) : $signed(sum2_q);
    res_ext_c = 32'(res_c);
    clamp_c   = sat_signed(res_ext_c, OUT_WIDTH);

    if (adv) begin
      sign1_d = in_sample[IN_WIDTH-1];
      mag1_d  = mag_c;
      sign2_d = sign1_q;
      sum2_d  = quot_c + MW'(inc_c);
      res3_d  = OUT_WIDTH'(clamp_c);
      sat3_d  = (clamp_c != res_ext_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign1_q <= 1'b0;
      mag1_q  <= '0;
      sign2_q <= 1'b0;
      sum2_q  <= '0;
      res3_q  <= '0;
      sat3_q  <= 1'b0;
    end else begin
      sign1_q <= sign1_d;
      mag1_q  <= mag1_d;
      sign2_q <= sign2_d;
      sum2_q  <= sum2_d;
      res3_q  <= res3_d;
      sat3_q  <= sat3_d;
    end
  end

  assign out_sample = res3_q;
  assign out_sat    = sat3_q;

endmodule

// File: rtl/div_pow2_round_pipe.sv
// Multi-channel signed divide-by-2^SHIFT with per-beat rounding mode and saturation.
// Three-stage pipeline with a single global advance (stall when output is held).
// Ports: clk, rst_n (async active-low), bus (slave side of div_pow2_round_pipe_if).
module div_pow2_round_pipe
  import div_round_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 12,
  parameter int unsigned OUT_WIDTH = 9,
  parameter int unsigned SHIFT     = 3,
  parameter int unsigned CHANNELS  = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  div_pow2_round_pipe_if.slave bus
);

  localparam int unsigned STAGES = 3;

  logic [STAGES-1:0]           vld_q, vld_d;
  round_mode_t                 mode1_q, mode1_d;
  logic                        advance_c;
  logic [CHANNELS*OUT_WIDTH-1:0] out_data_w;
  logic [CHANNELS-1:0]         out_sat_w;

  // Valid shift register and the mode that travels with the stage-1 beat.
  always_comb begin
    vld_d     = vld_q;
    mode1_d   = mode1_q;
    advance_c = !vld_q[STAGES-1] || bus.out_ready;
    if (advance_c) begin
      vld_d   = {vld_q[STAGES-2:0], bus.in_valid};
      mode1_d = bus.in_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      mode1_q <= MODE_TRUNC;
    end else begin
      vld_q   <= vld_d;
      mode1_q <= mode1_d;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    div_round_lane #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .adv        (advance_c),
      .mode_s1    (mode1_q),
      .in_sample  (bus.in_data[ch*IN_WIDTH +: IN_WIDTH]),
      .out_sample (out_data_w[ch*OUT_WIDTH +: OUT_WIDTH]),
      .out_sat    (out_sat_w[ch])
    );
  end

  assign bus.in_ready  = advance_c;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_data  = out_data_w;
  assign bus.out_sat   = out_sat_w;

endmodule

// File: tb/tb_div_pow2_round_pipe.sv
// Bench for div_pow2_round_pipe: scoreboard of expected beats from an arithmetic
// reference, separate output monitor, directed and random stimulus.
module tb_div_pow2_round_pipe;
  import div_round_pkg::*;

  localparam int IW   = 12;
  localparam int OW   = 9;
  localparam int SH   = 3;
  localparam int CH   = 2;
  localparam int HIST = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_pow2_round_pipe_if #(.CHANNELS(CH), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  div_pow2_round_pipe #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .CHANNELS(CH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [CH*OW-1:0] data;
    logic [CH-1:0]    sat;
    int               acc_cyc;
    bit               lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   acc_hist[HIST];
  bit   win    = 1'b0;
  bit   bp_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: divide magnitude by 2^SH, round from the remainder, re-sign, clamp.
  function automatic void ref_lane(input int x, input int m, output int r, output bit s);
    int d, a, q, rem, mag;
    bit neg;
    d   = 1 << SH;
    neg = (x < 0);
    a   = neg ? -x : x;
    q   = a / d;
    rem = a % d;
    case (m)
      0:       mag = q;
      1:       mag = (2 * rem >= d && rem != 0) ? q + 1 : q;
      2:       mag = (2 * rem > d || (2 * rem == d && (q % 2) == 1)) ? q + 1 : q;
      default: mag = (neg && rem != 0) ? q + 1 : q;
    endcase
    r = neg ? -mag : mag;
    s = 1'b0;
    if (r > 255) begin r = 255; s = 1'b1; end
    if (r < -256) begin r = -256; s = 1'b1; end
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    acc_hist[cyc % HIST] = 1'b0;
  end

  // Downstream ready: random when backpressure is enabled.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input int a, input int b, input int m, input bit lat);
    exp_t e;
    int r0, r1;
    bit s0, s1;
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = {12'(b), 12'(a)};
    bus.in_mode  = 2'(m);
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ref_lane(a, m, r0, s0);
        ref_lane(b, m, r1, s1);
        e.data    = {9'(r1), 9'(r0)};
        e.sat     = {s1, s0};
        e.acc_cyc = cyc;
        e.lat     = lat;
        sb.push_back(e);
        acc_hist[cyc % HIST] = 1'b1;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // Output monitor: handshake rule, stall stability, valid pattern, scoreboard.
  initial begin
    exp_t e;
    bit prev_stall;
    logic [CH*OW-1:0] prev_data;
    logic [CH-1:0] prev_sat;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_sat   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      chk("in_ready_rule", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'(1));
        chk("stall_data", 32'(bus.out_data), 32'(prev_data));
        chk("stall_sat", 32'(bus.out_sat), 32'(prev_sat));
      end
      if (win) chk("valid_pattern", 32'(bus.out_valid), 32'(acc_hist[(cyc - 3) % HIST]));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e.data));
          chk("out_sat", 32'(bus.out_sat), 32'(e.sat));
          if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'(3));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_sat   = bus.out_sat;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_mode  = MODE_TRUNC;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
    chk("reset_out_data", 32'(bus.out_data), 32'(0));
    chk("reset_out_sat", 32'(bus.out_sat), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'(1));
    idle(3);
    win = 1'b1;

    // Mode sweep.
    for (int m = 0; m < 4; m++) send(12, -12, m, 1'b1);
    // Ties.
    for (int m = 1; m < 4; m++) send(20, -20, m, 1'b1);
    // Extremes.
    send(2047, -2048, 1, 1'b1);
    send(2044, -2048, 1, 1'b1);
    send(0, 0, 3, 1'b1);
    send(-2048, 2047, 3, 1'b1);
    // Random beats, random modes, back to back.
    for (int i = 0; i < 16; i++) send(rnd_sample(), rnd_sample(), int'($urandom_range(0, 3)), 1'b1);
    idle(6);

    // Bubbles: 1,0,1,1,0.
    send(100, -100, 2, 1'b1);
    idle(1);
    send(-37, 37, 3, 1'b1);
    send(7, -9, 0, 1'b1);
    idle(1);
    idle(6);
    drain();

    // Backpressure.
    win   = 1'b0;
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++) send(rnd_sample(), rnd_sample(), int'($urandom_range(0, 3)), 1'b0);
    drain();
    bp_en = 1'b0;
    idle(4);

    // Reset with three beats in flight.
    send(12, -12, 1, 1'b1);
    send(20, -20, 2, 1'b1);
    send(2047, -2048, 1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midreset_out_data", 32'(bus.out_data), 32'(0));
    chk("midreset_out_sat", 32'(bus.out_sat), 32'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(6);
    win = 1'b1;
    send(-20, 20, 3, 1'b1);
    idle(5);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
